barrel_shift_arb: RTL
=====================

Name: barrel_shift_arb

Overview:
- Shares one 5-stage pipelined 32-bit logical-left barrel shifter between two requesters.
- Stage k shifts by 2^k when shamt bit k is set: stages 1, 2, 4, 8, 16.
- Round-robin (or fixed-priority) arbitration, valid/ready on both input ports and the result port; the requester ID travels down the pipe with its data.
- Sits between the two datapath clients and the shift resource; the pipeline registers are internal to this block.

Parameters:
- WIDTH, 32, data width; only 32 is supported.
- SHW, 5, shift-amount width; equals log2(WIDTH).
- PRIO_FIXED, 0, 0 = round-robin; 1 = req0 always wins a conflict.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_data  input  32  requester 0 operand.
- req0_shamt  input  5  requester 0 shift amount.
- req1_valid  input  1  requester 1 has an operation.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_data  input  32  requester 1 operand.
- req1_shamt  input  5  requester 1 shift amount.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  32  shifted result.
- res_id  output  1  requester that owns res_data.
- busy  output  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset (rst=1 at an edge):
  - All stage valids, res_valid, res_data, res_id and rr_ptr go to 0.
  - busy=0.
  - reqX_ready is 0 while rst is high.
  - Reset mid-operation discards every in-flight operation; nothing is emitted for it.
- Advance signal: adv = !res_valid || res_ready.
  - This is a global stall: when adv=0 every stage holds its value and no request is accepted.
- Grant, combinational:
  - Only one requester valid: that requester is granted.
  - Both valid, PRIO_FIXED=0: the requester indexed by rr_ptr is granted.
  - Both valid, PRIO_FIXED=1: requester 0 is granted.
- reqX_ready = adv && grant_X && !rst.
  - At most one ready is high per cycle.
  - reqX_ready never depends combinationally on res_valid's downstream path other than through adv.
- Transfer rule: a transfer occurs on an edge where valid && ready.
  - Stage 1 captures data shifted by shamt[0], plus shamt[4:1] and the requester ID.
  - Stage k captures stage k-1 data shifted by 2^(k-1) if shamt bit k-1 is set, and passes the remaining shamt bits and the ID.
  - Vacated bits fill with 0; bits shifted past bit 31 are discarded.
- Bubbles: if no request is accepted while adv=1, stage 1 valid becomes 0 and a bubble propagates. Bubbles are not collapsed.
- Latency: an operation accepted at edge N presents res_valid=1 after edge N+5 when no stall occurs. Throughput is 1 operation per cycle.
- Result hold: res_data and res_id stay stable while res_valid=1 and res_ready=0.
- Round-robin pointer: on every accepted transfer, rr_ptr becomes the index of the non-granted requester. It is unchanged when nothing is accepted.
- Result ordering: results leave strictly in acceptance order.
- busy = OR of the five stage valids.
- shamt = 0 passes the data unchanged, with latency still 5.
- shamt = 31 leaves only bit 0 of the input, moved to bit 31.
- Inputs are sampled only on the transfer edge.

Optional Feature:
- Macro: BARREL_SHIFT_ARB_ROTATE_EN.
- When defined:
  - Adds input ports req0_rot and req1_rot, 1 bit each.
  - The rot bit is carried down the pipe with its operation.
  - Stages whose operation has rot=1 perform a rotate-left: bits leaving bit 31 re-enter at bit 0.
- When undefined:
  - The ports are absent.
  - All operations are logical-left with zero fill.

Test Plan:
- Reset, then req0_valid=1, data=0x0000_0001, shamt=5, res_ready=1 -> req0_ready=1 on the first edge; res_valid=1, res_data=0x0000_0020, res_id=0 exactly 5 edges later.
- Both requesters valid every cycle with data 0xA0000001/0x1 and shamt 1/31, PRIO_FIXED=0 -> grants alternate 0,1,0,1 with req0 first after reset; results alternate 0x40000002 (id 0) and 0x80000000 (id 1).
- Same stimulus with PRIO_FIXED=1 -> req1_ready stays 0 and only id 0 results appear.
- Hold res_ready=0 for 8 cycles with a full pipe -> res_data/res_id stable, both reqX_ready=0, busy=1; release -> 5 remaining results drain one per cycle in order.
- Assert rst for one cycle while 3 operations are in flight -> res_valid=0, busy=0 next cycle; no stale result appears afterwards.
- With BARREL_SHIFT_ARB_ROTATE_EN: data=0x8000_0001, shamt=4, rot=1 -> 0x0000_0018; rot=0 -> 0x0000_0010.

Source files
------------

// File: rtl/barrel_shift_arb.sv
// barrel_shift_arb: two requesters share a 5-stage 32-bit left barrel shifter (stages 1,2,4,8,16) plus result register.
// Latency 5 cycles accept->res_valid, 1 op/cycle; res_valid && !res_ready stalls every stage and drops both readies.
// Optional BARREL_SHIFT_ARB_ROTATE_EN adds req0_rot/req1_rot selecting rotate-left instead of zero-fill.
module barrel_shift_arb #(
    parameter int WIDTH      = 32,
    parameter int SHW        = 5,
    parameter int PRIO_FIXED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shamt,
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
    input  logic             req0_rot,
    input  logic             req1_rot,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);
    localparam int NSTG = SHW;

    logic [NSTG-1:0]  stg_vld_q, stg_vld_d;
    logic [NSTG-1:0]  stg_id_q, stg_id_d;
    logic [WIDTH-1:0] stg_dat_q [NSTG];
    logic [WIDTH-1:0] stg_dat_d [NSTG];
    // Remaining shift bits, pre-shifted so each stage always consumes bit 0.
    logic [SHW-1:0]   stg_sh_q [NSTG-1];
    logic [SHW-1:0]   stg_sh_d [NSTG-1];
    logic [NSTG-2:0]  stg_rot_q, stg_rot_d;

    logic             res_vld_q, res_vld_d;
    logic [WIDTH-1:0] res_dat_q, res_dat_d;
    logic             res_id_q, res_id_d;
    logic             rr_ptr_q, rr_ptr_d;

    logic             adv, gnt0, gnt1, acc;
    logic [WIDTH-1:0] in_dat;
    logic [SHW-1:0]   in_sh;
    logic             in_rot;

    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d, input int amt,
                                                     input logic rot, input logic en);
        logic [2*WIDTH-1:0] w;
        w = {d, d} << amt;
        if (!en) return d;
        return rot ? w[2*WIDTH-1:WIDTH] : (d << amt);
    endfunction

    always_comb begin
        adv        = !res_vld_q || res_ready;
        gnt0       = req0_valid && (!req1_valid || (PRIO_FIXED != 0) || !rr_ptr_q);
        gnt1       = req1_valid && !gnt0;
        req0_ready = adv && gnt0 && !rst;
        req1_ready = adv && gnt1 && !rst;
        acc        = req0_ready || req1_ready;
        in_dat     = req1_ready ? req1_data : req0_data;
        in_sh      = req1_ready ? req1_shamt : req0_shamt;
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
        in_rot     = req1_ready ? req1_rot : req0_rot;
`else
        in_rot     = 1'b0;
`endif
        rr_ptr_d   = rr_ptr_q;
        if (acc) rr_ptr_d = req0_ready;

        stg_vld_d = stg_vld_q;
        stg_id_d  = stg_id_q;
        stg_rot_d = stg_rot_q;
        stg_dat_d = stg_dat_q;
        stg_sh_d  = stg_sh_q;
        res_vld_d = res_vld_q;
        res_dat_d = res_dat_q;
        res_id_d  = res_id_q;

        if (adv) begin
            stg_vld_d[0] = acc;
            if (acc) begin
                stg_dat_d[0] = stage_shift(in_dat, 1, in_rot, in_sh[0]);
                stg_sh_d[0]  = in_sh >> 1;
                stg_id_d[0]  = req1_ready;
                stg_rot_d[0] = in_rot;
            end
            for (int i = 1; i < NSTG; i++) begin
                stg_vld_d[i] = stg_vld_q[i-1];
                stg_id_d[i]  = stg_id_q[i-1];
                stg_dat_d[i] = stage_shift(stg_dat_q[i-1], 1 << i, stg_rot_q[i-1], stg_sh_q[i-1][0]);
            end
            for (int i = 1; i < NSTG - 1; i++) begin
                stg_sh_d[i]  = stg_sh_q[i-1] >> 1;
                stg_rot_d[i] = stg_rot_q[i-1];
            end
            res_vld_d = stg_vld_q[NSTG-1];
            if (stg_vld_q[NSTG-1]) begin
                res_dat_d = stg_dat_q[NSTG-1];
                res_id_d  = stg_id_q[NSTG-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld_q <= '0;
            stg_id_q  <= '0;
            stg_rot_q <= '0;
            for (int i = 0; i < NSTG; i++) stg_dat_q[i] <= '0;
            for (int i = 0; i < NSTG - 1; i++) stg_sh_q[i] <= '0;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
            res_id_q  <= 1'b0;
            rr_ptr_q  <= 1'b0;
        end else begin
            stg_vld_q <= stg_vld_d;
            stg_id_q  <= stg_id_d;
            stg_rot_q <= stg_rot_d;
            stg_dat_q <= stg_dat_d;
            stg_sh_q  <= stg_sh_d;
            res_vld_q <= res_vld_d;
            res_dat_q <= res_dat_d;
            res_id_q  <= res_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign res_valid = res_vld_q;
    assign res_data  = res_dat_q;
    assign res_id    = res_id_q;
    assign busy      = |stg_vld_q;

endmodule
